framing_encoding_param: RTL and testbench
=========================================

Name: framing_encoding_param

Overview:
Parametrised successor of the PHR/PSDU framing encoder. It buffers one byte-wide frame and appends an optional CRC-16. It applies optional PN9 whitening, then serializes LSB-first as SYM_WIDTH-bit symbols per clock. It sits between the MAC byte interface and the symbol mapper, and adds configurable symbol width, buffer depth, mode enables and error reporting.

Parameters:
SYM_WIDTH, 1, output bits per cycle; legal values 1, 2, 4, 8.
DEPTH, 127, maximum payload bytes buffered per frame.
CRC_EN, 1, 1 = append CRC-16/KERMIT (2 bytes); 0 = payload only.
WHITEN_EN, 1, 1 = XOR output bits with the PN9 sequence; 0 = bypass.
PN9_SEED, 9'h1FF, PN9 LFSR value loaded at each frame start.

Ports:
clk  input  1  system clock, all state on rising edge
reset_n  input  1  asynchronous active-low reset
phr_psdu_in  input  8  payload byte, sampled when valid is high
phr_psdu_in_valid  input  1  high for a contiguous run of cycles = one frame
framing_encoding_out  output  SYM_WIDTH  serialized symbol; bit 0 is the earliest in time
framing_encoding_out_valid  output  1  symbol qualifier
frame_busy  output  1  high in CAPTURE and SEND states
frame_error  output  1  one-cycle pulse on overflow or a rejected input

Behaviour:
- Reset: asynchronous, active-low. Forces state IDLE, counters 0, CRC 0x0000, LFSR PN9_SEED, and all outputs 0. No buffer clear is needed.
- States:
  - IDLE: on valid=1, write the byte to buf[0], count=1, start the CRC, go to CAPTURE.
  - CAPTURE: on valid=1 and count<DEPTH, write buf[count], count++, update the CRC.
  - CAPTURE overflow: on valid=1 and count==DEPTH, set the ovf flag. Further bytes are discarded.
  - CAPTURE, valid=0 and ovf=0: go to SEND, load LFSR=PN9_SEED, rd_ptr=0.
  - CAPTURE, valid=0 and ovf=1: pulse frame_error and go to IDLE. Nothing is transmitted.
  - SEND: each cycle emit SYM_WIDTH bits. Go to IDLE after the last symbol.
  - Total SEND cycles = (count + 2*CRC_EN) * 8 / SYM_WIDTH.
- Timing:
  - Let E be the edge that first samples valid=0 after a frame.
  - out_valid goes high after edge E+1 and stays high contiguously for exactly the SEND length.
  - out_valid drops after the edge that consumes the last symbol.
  - framing_encoding_out is registered and is 0 whenever out_valid=0.
- Byte order and bit order:
  - Payload bytes go out in arrival order, then CRC low byte, then CRC high byte.
  - Each byte goes out LSB first.
  - Symbol bit i = stream bit (k*SYM_WIDTH + i).
- CRC-16/KERMIT:
  - Reflected polynomial 0x8408, init 0x0000, no final XOR.
  - Computed bytewise during CAPTURE, one byte per cycle.
  - Check value: ASCII "123456789" gives 0x2189.
- PN9 whitening:
  - Feedback f = lfsr[0] ^ lfsr[5]; next lfsr = {f, lfsr[8:1]}.
  - Output bit = data bit ^ lfsr[0], then step the LFSR.
  - The LFSR steps SYM_WIDTH times per SEND cycle.
  - It covers the CRC bytes too; CRC is computed on un-whitened data.
  - With seed 1FF, the first byte mask is 0xFF.
- Input during SEND: any valid=1 pulses frame_error on the following cycle. The byte is dropped and the current frame is unaffected.
- Input in the first IDLE cycle after SEND is accepted normally. Back-to-back frames need no gap cycle beyond the return to IDLE.
- A one-byte frame (valid high for one cycle) is legal.
- Reset asserted mid-CAPTURE or mid-SEND aborts the frame immediately. The next frame after release behaves as a first frame.
- Widths: count and rd_ptr use clog2(DEPTH+1) bits. A bit-index counter of 3 bits wraps per byte.
- SYM_WIDTH not dividing 8 is illegal; the block stops elaboration.

Test Plan:
- Plain serialization: SYM_WIDTH=1, CRC_EN=0, WHITEN_EN=0; one byte 0xA5. Required: out_valid for 8 cycles, starting 2 edges after valid falls, with bits 1,0,1,0,0,1,0,1.
- CRC append: CRC_EN=1, WHITEN_EN=0; bytes "123456789" (0x31..0x39). Required: 88 valid cycles whose final 16 bits are 0x89 then 0x21, each LSB first.
- Whitening: WHITEN_EN=1, CRC_EN=0; bytes 0x07,0x03. Required: first byte on the wire 0xF8; second byte matches the PN9 model from seed 1FF; frame_busy high throughout.
- Wide symbols: SYM_WIDTH=4, no CRC or whitening; bytes 0x5A,0x3C. Required: symbols 0xA,0x5,0xC,0x3 on 4 consecutive cycles.
- Overflow: DEPTH=4; 5-byte frame. Required: frame_error pulses once the cycle after valid falls, out_valid never asserts, state returns to IDLE. A following 2-byte frame is then sent normally.
- Collision and reset: assert valid for 1 cycle mid-SEND. Required: frame_error pulse and unchanged output stream. Then drop reset_n mid-SEND. Required: out_valid=0, out=0 and busy=0 immediately; the next frame after release encodes correctly.

Source files
------------

// File: rtl/framing_encoding_param.sv
// Frame buffer and serializer: captures one byte-wide frame, optionally appends CRC-16/KERMIT,
// optionally whitens with PN9 and shifts the result out LSB-first as SYM_WIDTH-bit symbols.
module framing_encoding_param #(
  parameter int         SYM_WIDTH = 1,
  parameter int         DEPTH     = 127,
  parameter bit         CRC_EN    = 1'b1,
  parameter bit         WHITEN_EN = 1'b1,
  parameter logic [8:0] PN9_SEED  = 9'h1FF
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [7:0]           phr_psdu_in,
  input  logic                 phr_psdu_in_valid,
  output logic [SYM_WIDTH-1:0] framing_encoding_out,
  output logic                 framing_encoding_out_valid,
  output logic                 frame_busy,
  output logic                 frame_error
);

  localparam int             CW         = $clog2(DEPTH + 1);
  localparam int             AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0]  DEPTH_C    = CW'(DEPTH);
  localparam logic [CW-1:0]  ONE_C      = CW'(1);
  localparam logic [2:0]     STEP_C     = 3'(SYM_WIDTH % 8);
  localparam logic [2:0]     LAST_IDX_C = 3'(8 - SYM_WIDTH);

  if (!(SYM_WIDTH == 1 || SYM_WIDTH == 2 || SYM_WIDTH == 4 || SYM_WIDTH == 8)) begin : g_bad_sym_width
    $error("framing_encoding_param: SYM_WIDTH must divide 8");
  end

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    SEND    = 2'd2
  } state_t;

  function automatic logic [15:0] crc16_kermit(input logic [15:0] crc, input logic [7:0] data);
    logic [15:0] c;
    c = crc ^ {8'h00, data};
    for (int k = 0; k < 8; k++) begin
      c = c[0] ? ({1'b0, c[15:1]} ^ 16'h8408) : {1'b0, c[15:1]};
    end
    return c;
  endfunction

  // Returns {lfsr after SYM_WIDTH steps, mask bits in time order}.
  function automatic logic [SYM_WIDTH+8:0] pn9_run(input logic [8:0] seed);
    logic [8:0]           l;
    logic [SYM_WIDTH-1:0] m;
    l = seed;
    m = {SYM_WIDTH{1'b0}};
    for (int k = 0; k < SYM_WIDTH; k++) begin
      m[k] = l[0];
      l    = {l[0] ^ l[5], l[8:1]};
    end
    return {l, m};
  endfunction

  state_t               state_r;
  logic [7:0]           mem_r [DEPTH];
  logic [CW-1:0]        count_r;
  logic [CW-1:0]        rd_ptr_r;
  logic [2:0]           bit_idx_r;
  logic [15:0]          crc_r;
  logic [8:0]           lfsr_r;
  logic                 ovf_r;
  logic                 in_crc_r;
  logic                 crc_hi_r;
  logic [SYM_WIDTH-1:0] out_r;
  logic                 out_valid_r;
  logic                 busy_r;
  logic                 error_r;

  logic                 wr_en_s;
  logic [AW-1:0]        wr_addr_s;
  logic [7:0]           cur_byte_s;
  logic [SYM_WIDTH-1:0] data_sym_s;
  logic [SYM_WIDTH+8:0] pn9_s;
  logic [SYM_WIDTH-1:0] mask_s;
  logic                 end_of_byte_s;
  logic                 last_sym_s;

  // Buffer write port: byte 0 on frame start, then append while room remains.
  always_comb begin
    wr_en_s   = 1'b0;
    wr_addr_s = count_r[AW-1:0];
    if (phr_psdu_in_valid && (state_r == IDLE)) begin
      wr_en_s   = 1'b1;
      wr_addr_s = {AW{1'b0}};
    end else if (phr_psdu_in_valid && (state_r == CAPTURE) && (count_r < DEPTH_C)) begin
      wr_en_s = 1'b1;
    end else begin
      wr_en_s = 1'b0;
    end
  end

  // Payload storage; contents are don't-care until written, so it carries no reset.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_r[wr_addr_s] <= phr_psdu_in;
    end
  end

  // Byte currently being serialized: payload first, then CRC low and high bytes.
  always_comb begin
    if (!in_crc_r) begin
      cur_byte_s = mem_r[rd_ptr_r[AW-1:0]];
    end else if (crc_hi_r) begin
      cur_byte_s = crc_r[15:8];
    end else begin
      cur_byte_s = crc_r[7:0];
    end
    data_sym_s = {SYM_WIDTH{1'b0}};
    for (int k = 0; k < SYM_WIDTH; k++) begin
      data_sym_s[k] = cur_byte_s[3'(bit_idx_r + 3'(k))];
    end
  end

  assign pn9_s         = pn9_run(lfsr_r);
  assign mask_s        = WHITEN_EN ? pn9_s[SYM_WIDTH-1:0] : {SYM_WIDTH{1'b0}};
  assign end_of_byte_s = (bit_idx_r == LAST_IDX_C);
  assign last_sym_s    = end_of_byte_s &&
                         (CRC_EN ? (in_crc_r && crc_hi_r) : (rd_ptr_r == (count_r - ONE_C)));

  // Frame FSM with all outputs registered.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= IDLE;
      count_r     <= {CW{1'b0}};
      rd_ptr_r    <= {CW{1'b0}};
      bit_idx_r   <= 3'd0;
      crc_r       <= 16'h0000;
      lfsr_r      <= PN9_SEED;
      ovf_r       <= 1'b0;
      in_crc_r    <= 1'b0;
      crc_hi_r    <= 1'b0;
      out_r       <= {SYM_WIDTH{1'b0}};
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      error_r     <= 1'b0;
    end else begin
      error_r <= 1'b0;
      case (state_r)
        IDLE: begin
          out_r       <= {SYM_WIDTH{1'b0}};
          out_valid_r <= 1'b0;
          if (phr_psdu_in_valid) begin
            count_r <= ONE_C;
            crc_r   <= crc16_kermit(16'h0000, phr_psdu_in);
            ovf_r   <= 1'b0;
            busy_r  <= 1'b1;
            state_r <= CAPTURE;
          end else begin
            busy_r <= 1'b0;
          end
        end
        CAPTURE: begin
          out_r       <= {SYM_WIDTH{1'b0}};
          out_valid_r <= 1'b0;
          if (phr_psdu_in_valid) begin
            if (count_r < DEPTH_C) begin
              count_r <= count_r + ONE_C;
              crc_r   <= crc16_kermit(crc_r, phr_psdu_in);
            end else begin
              ovf_r <= 1'b1;
            end
          end else if (ovf_r) begin
            error_r <= 1'b1;
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end else begin
            lfsr_r    <= PN9_SEED;
            rd_ptr_r  <= {CW{1'b0}};
            bit_idx_r <= 3'd0;
            in_crc_r  <= 1'b0;
            crc_hi_r  <= 1'b0;
            state_r   <= SEND;
          end
        end
        SEND: begin
          out_r       <= data_sym_s ^ mask_s;
          out_valid_r <= 1'b1;
          lfsr_r      <= pn9_s[SYM_WIDTH+8:SYM_WIDTH];
          // A byte arriving mid-transmission is dropped and flagged.
          error_r     <= phr_psdu_in_valid;
          if (last_sym_s) begin
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end else begin
            bit_idx_r <= bit_idx_r + STEP_C;
            if (end_of_byte_s) begin
              if (in_crc_r) begin
                crc_hi_r <= 1'b1;
              end else if (rd_ptr_r == (count_r - ONE_C)) begin
                in_crc_r <= 1'b1;
              end else begin
                rd_ptr_r <= rd_ptr_r + ONE_C;
              end
            end else begin
              rd_ptr_r <= rd_ptr_r;
            end
          end
        end
        default: begin
          out_r       <= {SYM_WIDTH{1'b0}};
          out_valid_r <= 1'b0;
          busy_r      <= 1'b0;
          state_r     <= IDLE;
        end
      endcase
    end
  end

  assign framing_encoding_out       = out_r;
  assign framing_encoding_out_valid = out_valid_r;
  assign frame_busy                 = busy_r;
  assign frame_error                = error_r;

endmodule

// File: tb/tb_framing_encoding_param.sv
// Bench for framing_encoding_param: five configurations checked against a bit-stream reference model.
module tb_framing_encoding_param;

  localparam int NI = 5;

  function automatic int sw_of(input int i);
    case (i)
      0: return 1;
      1: return 1;
      2: return 2;
      3: return 4;
      default: return 8;
    endcase
  endfunction

  function automatic int dp_of(input int i);
    case (i)
      0: return 16;
      1: return 127;
      2: return 8;
      3: return 4;
      default: return 127;
    endcase
  endfunction

  function automatic int ce_of(input int i);
    return (i == 1 || i == 4) ? 1 : 0;
  endfunction

  function automatic int we_of(input int i);
    return (i == 2 || i == 4) ? 1 : 0;
  endfunction

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] din;
  logic       vld  [NI];
  logic [7:0] sym  [NI];
  logic       ov   [NI];
  logic       busy [NI];
  logic       fe   [NI];
  int         n_chk = 0;
  int         n_fail = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int W = sw_of(g);
    logic [W-1:0] o;
    framing_encoding_param #(
      .SYM_WIDTH (W),
      .DEPTH     (dp_of(g)),
      .CRC_EN    (ce_of(g) != 0),
      .WHITEN_EN (we_of(g) != 0),
      .PN9_SEED  (9'h1FF)
    ) u_dut (
      .clk                        (clk),
      .reset_n                    (rst_n),
      .phr_psdu_in                (din),
      .phr_psdu_in_valid          (vld[g]),
      .framing_encoding_out       (o),
      .framing_encoding_out_valid (ov[g]),
      .frame_busy                 (busy[g]),
      .frame_error                (fe[g])
    );
    assign sym[g] = 8'(o);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // CRC-16/KERMIT, one message bit at a time.
  function automatic logic [15:0] crc_model(input logic [7:0] d[$]);
    logic [15:0] c;
    logic        fb;
    c = 16'h0000;
    foreach (d[k]) begin
      for (int b = 0; b < 8; b++) begin
        fb = c[0] ^ d[k][b];
        c  = c >> 1;
        if (fb) c = c ^ 16'h8408;
      end
    end
    return c;
  endfunction

  // Expected symbol list: wire bit stream, whitened, then grouped into symbols.
  function automatic void build_exp(input int i, input logic [7:0] d[$], output logic [7:0] exp[$]);
    bit          bits[$];
    logic [15:0] c;
    logic [8:0]  l;
    logic [7:0]  s;
    int          w;
    exp = {};
    w = sw_of(i);
    if (d.size() > dp_of(i)) return;
    foreach (d[k]) for (int b = 0; b < 8; b++) bits.push_back(d[k][b]);
    if (ce_of(i) != 0) begin
      c = crc_model(d);
      for (int b = 0; b < 16; b++) bits.push_back(c[b]);
    end
    if (we_of(i) != 0) begin
      l = 9'h1FF;
      foreach (bits[k]) begin
        bits[k] = bits[k] ^ l[0];
        l = {l[0] ^ l[5], l[8:1]};
      end
    end
    for (int k = 0; k < bits.size() / w; k++) begin
      s = 8'h00;
      for (int b = 0; b < w; b++) s[b] = bits[k*w + b];
      exp.push_back(s);
    end
  endfunction

  // Drive one frame into instance i and follow its output; coll_at/rst_at < 0 disable those events.
  task automatic run_frame(input int i, input logic [7:0] d[$], input int coll_at, input int rst_at,
                           input bit b2b, output logic [15:0] head, output logic [15:0] tail);
    logic [7:0] exp[$];
    int         w;
    int         pos;
    bit         ovf;
    build_exp(i, d, exp);
    w    = sw_of(i);
    ovf  = d.size() > dp_of(i);
    head = 16'h0000;
    tail = 16'h0000;
    foreach (d[k]) begin
      din    = d[k];
      vld[i] = 1'b1;
      @(posedge clk); #1;
    end
    vld[i] = 1'b0;
    check_eq($sformatf("busy_capture_i%0d", i), busy[i], 1);
    @(posedge clk); #1;
    check_eq($sformatf("ov_at_E_i%0d", i), ov[i], 0);
    check_eq($sformatf("err_at_E_i%0d", i), fe[i], 32'(ovf));
    check_eq($sformatf("busy_at_E_i%0d", i), busy[i], 32'(!ovf));
    if (ovf) begin
      for (int k = 0; k < 3; k++) begin
        @(posedge clk); #1;
        check_eq($sformatf("ovf_no_out_i%0d", i), ov[i], 0);
        check_eq($sformatf("ovf_single_err_i%0d", i), fe[i], 0);
        check_eq($sformatf("ovf_idle_i%0d", i), busy[i], 0);
      end
      return;
    end
    for (int j = 0; j < exp.size(); j++) begin
      if (j == rst_at) begin
        rst_n = 1'b0;
        #1;
        check_eq($sformatf("rst_ov_i%0d", i), ov[i], 0);
        check_eq($sformatf("rst_sym_i%0d", i), sym[i], 0);
        check_eq($sformatf("rst_busy_i%0d", i), busy[i], 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        return;
      end
      if (j == coll_at) begin
        din    = 8'($urandom);
        vld[i] = 1'b1;
      end
      @(posedge clk); #1;
      if (j == coll_at) begin
        vld[i] = 1'b0;
        check_eq($sformatf("coll_err_i%0d", i), fe[i], 1);
      end else begin
        check_eq($sformatf("no_err_i%0d_s%0d", i, j), fe[i], 0);
      end
      check_eq($sformatf("sym_valid_i%0d_s%0d", i, j), ov[i], 1);
      check_eq($sformatf("sym_i%0d_s%0d", i, j), sym[i], exp[j]);
      for (int b = 0; b < w; b++) begin
        pos = j*w + b;
        if (pos < 16) head[pos] = sym[i][b];
        tail = {sym[i][b], tail[15:1]};
      end
    end
    if (b2b) return;
    @(posedge clk); #1;
    check_eq($sformatf("end_ov_i%0d", i), ov[i], 0);
    check_eq($sformatf("end_sym_i%0d", i), sym[i], 0);
    check_eq($sformatf("end_busy_i%0d", i), busy[i], 0);
  endtask

  initial begin
    logic [7:0]  d[$];
    logic [15:0] h;
    logic [15:0] t;
    int          inst;
    int          len;
    int          coll;
    rst_n = 1'b0;
    din   = 8'h00;
    foreach (vld[k]) vld[k] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < NI; k++) begin
      check_eq($sformatf("reset_ov_i%0d", k), ov[k], 0);
      check_eq($sformatf("reset_sym_i%0d", k), sym[k], 0);
      check_eq($sformatf("reset_busy_i%0d", k), busy[k], 0);
      check_eq($sformatf("reset_err_i%0d", k), fe[k], 0);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;

    d = {8'hA5};
    run_frame(0, d, -1, -1, 1'b0, h, t);
    check_eq("plain_byte", h[7:0], 8'hA5);

    d = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    run_frame(1, d, -1, -1, 1'b0, h, t);
    check_eq("kermit_tail", t, 16'h2189);

    d = {8'h07, 8'h03};
    run_frame(2, d, -1, -1, 1'b0, h, t);
    check_eq("pn9_first_byte", h[7:0], 8'hF8);

    d = {8'h5A, 8'h3C};
    run_frame(3, d, -1, -1, 1'b0, h, t);
    check_eq("wide_syms", h, 16'h3CA5 ^ 16'h0000 ^ {8'h3C, 8'h5A} ^ 16'h3CA5);

    d = {8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    run_frame(3, d, -1, -1, 1'b0, h, t);
    d = {8'h66, 8'h77};
    run_frame(3, d, -1, -1, 1'b0, h, t);

    d = {8'hDE, 8'hAD, 8'hBE, 8'hEF};
    run_frame(4, d, 2, -1, 1'b0, h, t);
    run_frame(4, d, -1, 3, 1'b0, h, t);
    run_frame(4, d, -1, -1, 1'b0, h, t);
    d = {8'h10, 8'h20, 8'h30};
    run_frame(0, d, -1, 9, 1'b0, h, t);
    run_frame(0, d, -1, -1, 1'b1, h, t);
    d = {8'hC3, 8'h5E};
    run_frame(0, d, -1, -1, 1'b0, h, t);

    for (int n = 0; n < 30; n++) begin
      inst = int'($urandom_range(0, NI - 1));
      len  = int'($urandom_range(1, (dp_of(inst) + 1 < 24) ? dp_of(inst) + 1 : 24));
      d    = {};
      for (int k = 0; k < len; k++) d.push_back(8'($urandom));
      coll = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, len*8/sw_of(inst) - 1)) : -1;
      run_frame(inst, d, coll, -1, 1'($urandom_range(0, 1)), h, t);
    end
    repeat (2) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
